fadd_arbiter: RTL and testbench

//  Shares one fadd unit (order/accepted/done handshake, 2 cycles from accept to done) between
//  N_REQ requesters, e.g. core FPU issue port and a vector/loader unit.

---
 rtl/fadd_arbiter_pkg.sv | 22 ++
 rtl/fadd_arbiter_rr.sv | 37 +++
 rtl/fadd_arbiter.sv | 118 +++++++++++
 tb/tb_fadd_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_arbiter_pkg.sv
// Shared definitions for the FP-unit arbiters: IEEE single field layout,
// arbiter FSM encoding and index-width helper.
package fadd_arbiter_pkg;

  localparam int FP_W         = 32;
  localparam int FP_SIGN_BIT  = 31;
  localparam int FP_EXP_MSB   = 30;
  localparam int FP_EXP_LSB   = 23;
  localparam int FP_MAN_MSB   = 22;
  localparam int FADD_LATENCY = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // A one-requester arbiter still needs a 1-bit index to keep port widths legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fadd_arbiter_rr.sv
// Combinational round-robin pick: first request at or above ptr, wrapping to 0.
// Shared by the fadd/fmul/fdiv arbiters.
module rr_arbiter
  import fadd_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    // First pass covers [ptr, N-1]; second pass supplies the wrapped part [0, ptr-1].
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
        any             = 1'b1;
        grant_onehot[i] = 1'b1;
        grant_idx       = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any             = 1'b1;
        grant_onehot[i] = 1'b1;
        grant_idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one fadd unit between N_REQ requesters: round-robin grant, add/sub by
// sign flip of rs2, registered result with a one-hot done pulse to the owner.
module fadd_arbiter
  import fadd_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_order,
  input  logic [N_REQ-1:0]          req_sub,
  input  logic [N_REQ*DATA_W-1:0]   req_rs1,
  input  logic [N_REQ*DATA_W-1:0]   req_rs2,
  output logic [N_REQ-1:0]          req_accepted,
  output logic [N_REQ-1:0]          req_done,
  output logic [DATA_W-1:0]         rd,
  output logic                      fa_order,
  output logic [DATA_W-1:0]         fa_rs1,
  output logic [DATA_W-1:0]         fa_rs2,
  input  logic                      fa_accepted,
  input  logic                      fa_done,
  input  logic [DATA_W-1:0]         fa_rd
);

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [N_REQ-1:0]   r_req_done;
  logic [DATA_W-1:0]  r_rd;

  logic [N_REQ-1:0]   w_grant_oh;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;
  logic               w_take;
  logic               w_sub;
  logic [DATA_W-1:0]  w_rs1;
  logic [DATA_W-1:0]  w_rs2;

  // Subtraction only flips the sign bit, so NaN/inf payloads pass through untouched.
  function automatic logic [DATA_W-1:0] apply_sub(input logic [DATA_W-1:0] x, input logic sub);
    return {x[DATA_W-1] ^ sub, x[DATA_W-2:0]};
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_REQ - 1)) ? '0 : g + IDX_W'(1);
  endfunction

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req          (req_order),
    .ptr          (r_rr_ptr),
    .grant_onehot (w_grant_oh),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  always_comb begin
    w_rs1 = '0;
    w_rs2 = '0;
    w_sub = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_rs1 = req_rs1[i*DATA_W +: DATA_W];
        w_rs2 = req_rs2[i*DATA_W +: DATA_W];
        w_sub = req_sub[i];
      end
    end
  end

  // Handshake outputs are gated by rstn so nothing is offered while reset is held.
  assign fa_order     = rstn && (r_state == ARB_IDLE) && w_any;
  assign w_take       = fa_order && fa_accepted;
  assign req_accepted = w_take ? w_grant_oh : '0;
  assign fa_rs1       = w_rs1;
  assign fa_rs2       = apply_sub(w_rs2, w_sub);
  assign req_done     = r_req_done;
  assign rd           = r_rd;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_req_done <= '0;
      r_rd       <= '0;
    end else begin
      r_req_done <= '0;
      case (r_state)
        ARB_IDLE: begin
          if (w_take) begin
            r_owner  <= w_grant_idx;
            r_rr_ptr <= next_ptr(w_grant_idx);
            r_state  <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (fa_done) begin
            r_rd       <= fa_rd;
            r_req_done <= N_REQ'(1) << r_owner;
            r_state    <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Protocol violations by the fadd are dropped by the FSM but flagged here.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(r_state == ARB_IDLE && fa_done));
      assert (!(r_state == ARB_BUSY && fa_accepted));
    end
  end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter with N_REQ=2 and a behavioural 2-cycle fadd model.
module tb_fadd_arbiter;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [1:0]  req_order;
  logic [1:0]  req_sub;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic [1:0]  req_accepted;
  logic [1:0]  req_done;
  logic [31:0] rd;
  logic        fa_order;
  logic [31:0] fa_rs1;
  logic [31:0] fa_rs2;
  logic        fa_accepted;
  logic        fa_done;
  logic [31:0] fa_rd;

  fadd_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_order    (req_order),
    .req_sub      (req_sub),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_accepted (req_accepted),
    .req_done     (req_done),
    .rd           (rd),
    .fa_order     (fa_order),
    .fa_rs1       (fa_rs1),
    .fa_rs2       (fa_rs2),
    .fa_accepted  (fa_accepted),
    .fa_done      (fa_done),
    .fa_rd        (fa_rd)
  );

  // ---------------- behavioural fadd: accept at t, done at t+2 ----------------
  function automatic real sp2r(input logic [31:0] x);
    real r;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    real         a;
    int          e;
    logic        s;
    logic [22:0] m;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e), m};
  endfunction

  logic        m_busy;
  logic [1:0]  m_cnt;
  logic [31:0] m_res;

  assign fa_accepted = fa_order && !m_busy;
  assign fa_done     = m_busy && (m_cnt == 2'd2);
  assign fa_rd       = fa_done ? m_res : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (!rstn) begin
      m_busy <= 1'b0;
      m_cnt  <= 2'd0;
      m_res  <= 32'h0;
    end else if (fa_accepted) begin
      m_busy <= 1'b1;
      m_cnt  <= 2'd1;
      m_res  <= r2sp(sp2r(fa_rs1) + sp2r(fa_rs2));
    end else if (m_busy) begin
      if (m_cnt == 2'd2) m_busy <= 1'b0;
      else               m_cnt  <= m_cnt + 2'd1;
    end
  end

  // ---------------- scoreboard and requester state ----------------
  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    logic [1:0]  oh;
    logic [31:0] rd;
  } exp_t;

  op_t  opq0[$];
  op_t  opq1[$];
  exp_t sb[$];
  int   acc_cyc[$];
  int   acc_idx[$];
  int   done_cyc[$];
  logic [1:0]  gate;
  logic [31:0] last_rs1;
  logic [31:0] last_rs2;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_inputs();
    if (!req_order[0] && gate[0] && opq0.size() > 0) begin
      req_order[0]  = 1'b1;
      req_sub[0]    = opq0[0].sub;
      req_rs1[31:0] = opq0[0].a;
      req_rs2[31:0] = opq0[0].b;
    end
    if (!req_order[1] && gate[1] && opq1.size() > 0) begin
      req_order[1]   = 1'b1;
      req_sub[1]     = opq1[0].sub;
      req_rs1[63:32] = opq1[0].a;
      req_rs2[63:32] = opq1[0].b;
    end
  endtask

  task automatic issue(input int i, input logic sub, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
    op_t  o;
    exp_t x;
    o.sub = sub; o.a = a; o.b = b;
    x.oh  = (i == 0) ? 2'b01 : 2'b10;
    x.rd  = e;
    sb.push_back(x);
    if (i == 0) opq0.push_back(o);
    else        opq1.push_back(o);
    load_inputs();
  endtask

  // One clock: observe mid-cycle, let the edge happen, then update requesters.
  task automatic step();
    logic [1:0] acc;
    exp_t       x;
    @(negedge clk);
    if (req_done !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(req_done), 32'h0);
      end else begin
        x = sb.pop_front();
        check("done_onehot", 32'(req_done), 32'(x.oh));
        check("done_rd", rd, x.rd);
        done_cyc.push_back(cyc);
      end
    end
    acc = req_accepted;
    if (acc != 2'b00) begin
      acc_cyc.push_back(cyc);
      acc_idx.push_back(acc[1] ? 1 : 0);
      last_rs1 = fa_rs1;
      last_rs2 = fa_rs2;
      check("acc_onehot", 32'($onehot(acc)), 32'd1);
      check("acc_has_order", 32'(acc & req_order), 32'(acc));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc[0]) begin opq0.delete(0); req_order[0] = 1'b0; end
    if (acc[1]) begin opq1.delete(0); req_order[1] = 1'b0; end
    load_inputs();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin step(); n++; end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_acc(input int want, input int budget);
    int n = 0;
    while (acc_cyc.size() < want && n < budget) begin step(); n++; end
    check("acc_timeout", 32'(acc_cyc.size()), 32'(want));
  endtask

  task automatic wait_done(input int want, input int budget);
    int n = 0;
    while (done_cyc.size() < want && n < budget) begin step(); n++; end
    check("done_timeout", 32'(done_cyc.size()), 32'(want));
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    acc_idx.delete();
    done_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    req_order = 2'b00;
    req_sub   = 2'b00;
    req_rs1   = '0;
    req_rs2   = '0;
    gate      = 2'b11;
    step();
    step();
    check("rst_req_done", 32'(req_done), 32'h0);
    check("rst_rd", rd, 32'h0);
    check("rst_fa_order", 32'(fa_order), 32'h0);
    check("rst_req_acc", 32'(req_accepted), 32'h0);
    rstn = 1'b1;
    step();

    // Single add on req0: 1.0 + 2.0
    clear_logs();
    issue(0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000);
    drain(20);
    check("t1_nacc", 32'(acc_cyc.size()), 32'd1);
    check("t1_ndone", 32'(done_cyc.size()), 32'd1);
    if (acc_cyc.size() == 1 && done_cyc.size() == 1) begin
      check("t1_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd3);
      check("t1_idx", 32'(acc_idx[0]), 32'd0);
    end
    check("t1_fa_rs1", last_rs1, 32'h3F800000);
    check("t1_fa_rs2", last_rs2, 32'h40000000);
    step();
    step();
    check("t1_rd_held", rd, 32'h40400000);
    check("t1_done_low", 32'(req_done), 32'h0);

    // Single sub on req1: 3.0 - 1.0, rs2 sign flipped on the way out
    clear_logs();
    issue(1, 1'b1, 32'h40400000, 32'h3F800000, 32'h40000000);
    drain(20);
    check("t2_fa_rs1", last_rs1, 32'h40400000);
    check("t2_fa_rs2", last_rs2, 32'hBF800000);
    check("t2_nacc", 32'(acc_idx.size()), 32'd1);
    if (acc_idx.size() == 1) check("t2_idx", 32'(acc_idx[0]), 32'd1);

    // Both requesters held from reset, four ops each: strict alternation, 3 cycles apart
    rstn = 1'b0;
    clear_logs();
    issue(0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    issue(1, 1'b0, 32'h40000000, 32'h40000000, 32'h40800000);
    issue(0, 1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000);
    issue(1, 1'b1, 32'h40800000, 32'h3F800000, 32'h40400000);
    issue(0, 1'b0, 32'h3F000000, 32'h3F000000, 32'h3F800000);
    issue(1, 1'b0, 32'h3FC00000, 32'h3F000000, 32'h40000000);
    issue(0, 1'b0, 32'h40800000, 32'h40800000, 32'h41000000);
    issue(1, 1'b1, 32'h41000000, 32'h40800000, 32'h40800000);
    step();
    check("t3_rst_fa_order", 32'(fa_order), 32'h0);
    check("t3_rst_acc", 32'(req_accepted), 32'h0);
    rstn = 1'b1;
    drain(100);
    check("t3_nacc", 32'(acc_cyc.size()), 32'd8);
    for (int k = 0; k < acc_idx.size(); k++)
      check("t3_order", 32'(acc_idx[k]), 32'(k % 2));
    for (int k = 1; k < acc_cyc.size(); k++)
      check("t3_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);

    // 1.0 - 1.0 -> +0 and a single-cycle done pulse
    clear_logs();
    issue(0, 1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000);
    drain(20);
    check("t4_rd_zero", rd, 32'h00000000);
    check("t4_pulse_len", 32'(req_done), 32'h0);
    step();
    step();
    check("t4_ndone", 32'(done_cyc.size()), 32'd1);

    // Reset one cycle after an accept: op vanishes, pointer returns to 0
    clear_logs();
    issue(0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    wait_acc(1, 20);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    sb.delete();
    check("t5_rd_rst", rd, 32'h0);
    check("t5_done_rst", 32'(req_done), 32'h0);
    for (int k = 0; k < 5; k++) step();
    check("t5_no_done", 32'(done_cyc.size()), 32'd0);
    clear_logs();
    issue(0, 1'b0, 32'h3F800000, 32'h40400000, 32'h40800000);
    issue(1, 1'b0, 32'h40800000, 32'h40800000, 32'h41000000);
    drain(30);
    check("t5_nacc", 32'(acc_idx.size()), 32'd2);
    if (acc_idx.size() == 2) begin
      check("t5_first", 32'(acc_idx[0]), 32'd0);
      check("t5_second", 32'(acc_idx[1]), 32'd1);
    end
    check("t5_rd", rd, 32'h41000000);

    // req0 raised then dropped while req1 is in flight; served only when re-raised
    clear_logs();
    gate[0] = 1'b0;
    issue(1, 1'b0, 32'h40000000, 32'h3F800000, 32'h40400000);
    issue(0, 1'b0, 32'h3FC00000, 32'h3F000000, 32'h40000000);
    wait_acc(1, 20);
    gate[0] = 1'b1;
    load_inputs();
    step();
    gate[0] = 1'b0;
    req_order[0] = 1'b0;
    wait_done(1, 20);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_idle_fa_order", 32'(fa_order), 32'h0);
    end
    check("t6_nacc_dropped", 32'(acc_cyc.size()), 32'd1);
    check("t6_ndone_dropped", 32'(done_cyc.size()), 32'd1);
    gate[0] = 1'b1;
    load_inputs();
    drain(20);
    check("t6_nacc", 32'(acc_idx.size()), 32'd2);
    if (acc_idx.size() == 2) check("t6_second", 32'(acc_idx[1]), 32'd0);
    check("t6_fa_rs1", last_rs1, 32'h3FC00000);
    check("t6_rd", rd, 32'h40000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
